// File: rtl/alu_serial_exec.sv
// Execute unit: single-cycle logic/arith/compare ops plus 1-bit-per-cycle serial shifts.
// Latency 1 cycle, or shamt+1 for shifts; ready drops while shifting and starts are ignored then.
module alu_serial_exec #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

  state_t                state, state_n;
  shkind_t               kind, kind_q;
  logic                  is_shift;
  logic [SHAMT_W-1:0]    shamt, cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_step, single_res;
  logic                  accept, slt;

  assign shamt  = SrcB[SHAMT_W-1:0];
  assign ready  = (state != SHIFT);
  assign done   = (state == FIN);
  assign accept = start && ready;
  assign slt    = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    single_res = '0;
    is_shift   = 1'b0;
    kind       = SH_LL;
    case (Operation)
      4'b0000: single_res = SrcA & SrcB;
      4'b0001: single_res = SrcA | SrcB;
      4'b0010: single_res = SrcA + SrcB;
      4'b0011: single_res = SrcA ^ SrcB;
      4'b0110: single_res = SrcA - SrcB;
      4'b0111,
      4'b1111: single_res = {{(DATA_WIDTH-1){1'b0}}, slt};
      4'b1000: single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      // Shift ops land here only with shamt=0 in practice: result is SrcA unchanged.
      4'b0100: begin is_shift = 1'b1; kind = SH_LL; single_res = SrcA; end
      4'b0101: begin is_shift = 1'b1; kind = SH_RL; single_res = SrcA; end
      4'b1001: begin is_shift = 1'b1; kind = SH_RA; single_res = SrcA; end
      default: single_res = '0;
    endcase
  end

  always_comb begin
    shreg_step = shreg;
    case (kind_q)
      SH_LL:   shreg_step = {shreg[DATA_WIDTH-2:0], 1'b0};
      SH_RL:   shreg_step = {1'b0, shreg[DATA_WIDTH-1:1]};
      SH_RA:   shreg_step = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
      default: shreg_step = shreg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_n = (is_shift && shamt != '0) ? SHIFT : FIN;
        else       state_n = IDLE;
      end
      SHIFT:   if (cnt <= SHAMT_W'(1)) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q    <= SH_LL;
      cnt       <= '0;
      shreg     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else if (accept) begin
      kind_q <= kind;
      if (is_shift && shamt != '0) begin
        shreg <= SrcA;
        cnt   <= shamt;
      end else begin
        ALUResult <= single_res;
        Zero      <= (single_res == '0);
      end
    end else if (state == SHIFT) begin
      shreg <= shreg_step;
      cnt   <= cnt - SHAMT_W'(1);
      // The last step writes the result directly so FIN is entered with it valid.
      if (cnt <= SHAMT_W'(1)) begin
        ALUResult <= shreg_step;
        Zero      <= (shreg_step == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec with immediate-assertion checks.
module tb_alu_serial_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        start;
  logic        ready, done, Zero;
  logic [31:0] ALUResult;

  int total = 0;
  int bad   = 0;
  int lat;

  alu_serial_exec dut (
    .clk(clk), .reset(reset), .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .start(start), .ready(ready), .done(done), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency/result/Zero.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    Operation = op; SrcA = a; SrcB = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (exp_lat > 1) check({tag, "_ready_low"}, 32'(ready), 32'd0);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, ALUResult, exp_res);
    check({tag, "_zero"}, 32'(Zero), 32'(exp_res == 32'd0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Operation = 4'd0; SrcA = '0; SrcB = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_res",   ALUResult,  32'd0);
    check("rst_zero",  32'(Zero),  32'd1);

    run_op("add",  4'b0010, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1);
    run_op("sub",  4'b0110, 32'd5,         32'd5,        32'h0,         1);
    run_op("slt",  4'b0111, 32'hFFFF_FFFF, 32'h1,        32'h1,         1);
    run_op("slt2", 4'b1111, 32'h1,         32'hFFFF_FFFF, 32'h0,        1);
    run_op("eq",   4'b1000, 32'h1234,      32'h1234,     32'h1,         1);
    run_op("and",  4'b0000, 32'hF0F0,      32'hFF00,     32'hF000,      1);
    run_op("or",   4'b0001, 32'hF0F0,      32'hFF00,     32'hFFF0,      1);
    run_op("xor",  4'b0011, 32'hF0F0,      32'hFF00,     32'h0FF0,      1);
    run_op("undef", 4'b1010, 32'hF0F0,     32'hFF00,     32'h0,         1);
    run_op("sll31", 4'b0100, 32'h1,        32'd31,       32'h8000_0000, 32);
    run_op("sra4", 4'b1001, 32'h8000_0000, 32'd4,        32'hF800_0000, 5);
    run_op("srl4", 4'b0101, 32'h8000_0000, 32'h24,       32'h0800_0000, 5);
    run_op("sll0", 4'b0100, 32'hABCD,      32'h20,       32'hABCD,      1);

    // start held through a 10-step shift while operands change
    Operation = 4'b0100; SrcA = 32'd3; SrcB = 32'd10; start = 1'b1;
    tick();
    Operation = 4'b0010; SrcA = 32'hFFFF; SrcB = 32'h1;
    check("hold_ready_low", 32'(ready), 32'd0);
    check("hold_res_stable", ALUResult, 32'hABCD);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("hold_lat", lat, 11);
    check("hold_res", ALUResult, 32'h0000_0C00);
    tick();
    start = 1'b0;
    check("hold_second_done", 32'(done), 32'd1);
    check("hold_second_res", ALUResult, 32'h0001_0000);
    tick();
    check("hold_done_drop", 32'(done), 32'd0);

    // back-to-back: ADD accepted in the FIN cycle of an SLL
    Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("b2b_no_early_done", 32'(done), 32'd0);
    tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_res1", ALUResult, 32'd4);
    Operation = 4'b0010; SrcA = 32'd10; SrcB = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_res2", ALUResult, 32'd30);
    tick();
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_res_hold", ALUResult, 32'd30);

    // reset in the middle of a 20-step shift
    Operation = 4'b0101; SrcA = 32'hFFFF_FFFF; SrcB = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("mid_no_done", 32'(done), 32'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_res",   ALUResult,  32'd0);
    check("mid_rst_zero",  32'(Zero),  32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mid_rst_quiet", 32'(done), 32'd0);
    end
    run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1);

    // reset wins over a simultaneous start
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    check("rst_start_res", ALUResult, 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    tick();
    check("rst_start_done2", 32'(done), 32'd0);
    check("rst_start_zero", 32'(Zero), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
